// File: rtl/adder_pkg.sv
// Shared constants for the bit-serial adder: FSM state encoding and default width.
// Latency: none (declarations only).
// Backpressure: not applicable.
package adder_pkg;

   // Default operand/sum width; legal range is 1..32.
   localparam int ADD_WIDTH_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage : adder_pkg

// File: rtl/full_add.sv
// One-bit full adder built from two half-add stages whose carries are ORed.
// Latency: purely combinational.
// Backpressure: not applicable.
module full_add (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic co
);

   logic hs1_s;
   logic hs1_c;
   logic hs2_c;

   // First half-add stage combines the operand bits.
   assign hs1_s = a ^ b;
   assign hs1_c = a & b;

   // Second half-add stage folds in the incoming carry.
   assign s     = hs1_s ^ cin;
   assign hs2_c = hs1_s & cin;

   // At most one of the two stage carries can be set, so OR gives the carry-out.
   assign co    = hs1_c | hs2_c;

endmodule : full_add

// File: rtl/serial_add.sv
// Bit-serial unsigned adder: one sum bit per clock, LSB first, with carry-out flag.
// Latency: operands accepted on edge T give out_valid after edge T+WIDTH.
// Backpressure: in_ready only in IDLE; result held stable in DONE until out_ready.
module serial_add
   import adder_pkg::*;
#(
   parameter int WIDTH = ADD_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t           state_q,  state_d;
   logic [WIDTH-1:0] a_sh_q,   a_sh_d;
   logic [WIDTH-1:0] b_sh_q,   b_sh_d;
   logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
   logic             carry_q,  carry_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;

   logic             bit_s;
   logic             bit_co;

   // The single adder cell shared by every bit position.
   full_add u_full_add (
      .a   (a_sh_q[0]),
      .b   (b_sh_q[0]),
      .cin (carry_q),
      .s   (bit_s),
      .co  (bit_co)
   );

   // Handshake outputs depend on state only; sum/carry come straight from registers.
   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign sum       = sum_sh_q;
   assign carry     = carry_q;

   // Next-state and datapath updates: load on accept, shift one bit per RUN cycle.
   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      sum_sh_d = sum_sh_q;
      carry_d  = carry_q;
      cnt_d    = cnt_q;

      unique case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_sh_d  = a;
               b_sh_d  = b;
               carry_d = 1'b0;
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            // Shift-then-insert keeps this legal when WIDTH is 1.
            sum_sh_d            = sum_sh_q >> 1;
            sum_sh_d[WIDTH-1]   = bit_s;
            a_sh_d              = a_sh_q >> 1;
            b_sh_d              = b_sh_q >> 1;
            carry_d             = bit_co;
            cnt_d               = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset discards any partial result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         sum_sh_q <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         sum_sh_q <= sum_sh_d;
         carry_q  <= carry_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule : serial_add
